// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared types: FSM states, ALU opcodes, widths.
// Optional result register build: ALU_ARB_OUTREG_EN.
package alu_arb_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int ID_W   = 1;
  localparam int NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [OP_W-1:0] ALU_AND = 4'b0001;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [OP_W-1:0] ALU_LUI = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SRL = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SRA = 4'b1111;

  function automatic logic is_zero(
    input logic [DATA_W-1:0] v
  );
    return v == '0;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters,
// the response consumer and the ALU arbiter.
interface alu_arb_if;
  import alu_arb_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_aluc;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_aluc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_s;
  logic              rsp_z;

  modport slave (
    input  req_valid,
    input  req0_a, req0_b, req0_aluc,
    input  req1_a, req1_b, req1_aluc,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_z
  );

  modport master (
    output req_valid,
    output req0_a, req0_b, req0_aluc,
    output req1_a, req1_b, req1_aluc,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_z
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Datapath ALU: combinational a/b/aluc -> s/z.
// Opcodes outside the table give s=0, z=1.
module alu
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   aluc,
  output logic [DATA_W-1:0] s,
  output logic              z
);
  always_comb begin
    s = '0;
    case (aluc)
      ALU_ADD: s = a + b;
      ALU_SUB: s = a - b;
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      ALU_XOR: s = a ^ b;
      ALU_LUI: s = {b[15:0], 16'h0000};
      // shift amount comes from a, shifted value from b
      ALU_SLL: s = b << a[4:0];
      ALU_SRL: s = b >> a[4:0];
      ALU_SRA: s = $unsigned($signed(b) >>> a[4:0]);
      default: s = '0;
    endcase
  end

  assign z = is_zero(s);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters.
// ALU_ARB_OUTREG_EN adds an EXEC state and result register.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  alu_arb_if.slave  bus
);
`ifdef ALU_ARB_OUTREG_EN
  localparam arb_state_e FILL = EXEC;
`else
  localparam arb_state_e FILL = RESP;
`endif

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]   op_aluc_q, op_aluc_d;
  logic              op_id_q, op_id_d;

  logic              gnt_vld;
  logic              gnt_id;
  logic              slot_free;
  logic              accept;
  logic [DATA_W-1:0] alu_s;
  logic              alu_z;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (bus.req_valid == 2'b11): begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_q;
      end
      (bus.req_valid == 2'b01): begin
        gnt_vld = 1'b1;
      end
      (bus.req_valid == 2'b10): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      default: ;
    endcase
  end

  // drain-and-refill in one cycle: rsp_ready feeds req_ready
  assign slot_free = (state_q == IDLE) ||
                     (state_q == RESP && bus.rsp_ready);
  assign accept    = gnt_vld && slot_free && !reset;

  assign bus.req_ready = {accept && gnt_id,
                          accept && !gnt_id};

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_aluc_d = op_aluc_q;
    op_id_d   = op_id_q;

    if (accept) begin
      last_d  = gnt_id;
      op_id_d = gnt_id;
      if (gnt_id) begin
        op_a_d    = bus.req1_a;
        op_b_d    = bus.req1_b;
        op_aluc_d = bus.req1_aluc;
      end else begin
        op_a_d    = bus.req0_a;
        op_b_d    = bus.req0_b;
        op_aluc_d = bus.req0_aluc;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FILL;
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = accept ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_aluc_q <= ALU_ADD;
      op_id_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_aluc_q <= op_aluc_d;
      op_id_q   <= op_id_d;
    end
  end

  alu u_alu (
    .a    (op_a_q),
    .b    (op_b_q),
    .aluc (op_aluc_q),
    .s    (alu_s),
    .z    (alu_z)
  );

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = op_id_q;

`ifdef ALU_ARB_OUTREG_EN
  logic [DATA_W-1:0] res_s_q, res_s_d;
  logic              res_z_q, res_z_d;

  always_comb begin
    res_s_d = res_s_q;
    res_z_d = res_z_q;
    if (state_q == EXEC) begin
      res_s_d = alu_s;
      res_z_d = alu_z;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_s_q <= '0;
      res_z_q <= 1'b1;
    end else begin
      res_s_q <= res_s_d;
      res_z_q <= res_z_d;
    end
  end

  assign bus.rsp_s = res_s_q;
  assign bus.rsp_z = res_z_q;
`else
  assign bus.rsp_s = alu_s;
  assign bus.rsp_z = alu_z;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors,
// corner sequences and a randomized scoreboard run.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  alu_arb_if bus();

  alu_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int sh;
    sh = int'(a % 32);
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return b * 32'h0001_0000;
      4'b0011: return b * (32'd1 << sh);
      4'b0111: return b / (32'd1 << sh);
      4'b1111: begin
        if (b[31]) return ~((~b) / (32'd1 << sh));
        return b / (32'd1 << sh);
      end
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] s;
    logic        z;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] s;
    logic        z;
    int          k;
  } ent_t;

  vec_t vt[11];
  ent_t q[$];
  logic [1:0] acc_bits = 2'b00;
  logic       last_m   = 1'b1;
  logic       mon_en   = 1'b0;
  int         ncyc     = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_aluc = op;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_aluc = op;
    end
  endtask

  task automatic wait_acc(input string nm, input logic id);
    int w;
    w = 0;
    @(negedge clock);
    while (!bus.req_ready[id] && w < 10) begin
      @(negedge clock);
      w++;
    end
    chk(nm, 32'(bus.req_ready[id]), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.rsp_valid && lat < 8);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    set_req(v.id, v.a, v.b, v.op);
    bus.req_valid = v.id ? 2'b10 : 2'b01;
    wait_acc({nm, " accept"}, v.id);
    step();
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk({nm, " latency"}, 32'(lat), 32'(LAT));
    chk({nm, " rsp_id"}, 32'(bus.rsp_id), 32'(v.id));
    chk({nm, " rsp_s"}, bus.rsp_s, v.s);
    chk({nm, " rsp_z"}, 32'(bus.rsp_z), 32'(v.z));
    step();
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      logic       free;
      logic       exp_v;
      logic [1:0] exp_rdy;
      logic       id;
      ncyc++;
      exp_v = (q.size() != 0) && (ncyc - q[0].k >= LAT);
      free  = (q.size() == 0) || (exp_v && bus.rsp_ready);
      exp_rdy = 2'b00;
      if (free) begin
        case (bus.req_valid)
          2'b11:   exp_rdy = last_m ? 2'b01 : 2'b10;
          2'b01:   exp_rdy = 2'b01;
          2'b10:   exp_rdy = 2'b10;
          default: exp_rdy = 2'b00;
        endcase
      end
      chk("rnd req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rnd rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
      if (exp_v && bus.rsp_valid) begin
        chk("rnd rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        chk("rnd rsp_s", bus.rsp_s, q[0].s);
        chk("rnd rsp_z", 32'(bus.rsp_z), 32'(q[0].z));
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() != 0)
        void'(q.pop_front());
      acc_bits = bus.req_valid & bus.req_ready;
      if (acc_bits != 2'b00) begin
        ent_t e;
        id   = acc_bits[1];
        e.id = id;
        e.s  = id ? ref_alu(bus.req1_aluc, bus.req1_a, bus.req1_b)
                  : ref_alu(bus.req0_aluc, bus.req0_a, bus.req0_b);
        e.z  = (e.s == 32'd0);
        e.k  = ncyc;
        q.push_back(e);
        last_m = id;
      end
    end
  end

  initial begin
    int lat;
    int got[$];
    logic [3:0] ops[11];

    vt[0]  = '{1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0};
    vt[1]  = '{1'b1, 32'd7, 32'd7, 4'b0100, 32'd0, 1'b1};
    vt[2]  = '{1'b0, 32'd3, 32'd5, 4'b0100, 32'hFFFF_FFFE, 1'b0};
    vt[3]  = '{1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0001,
               32'h0000_F000, 1'b0};
    vt[4]  = '{1'b0, 32'h0000_F0F0, 32'h0000_0F00, 4'b0101,
               32'h0000_FFF0, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_00FF, 32'h0000_000F, 4'b0010,
               32'h0000_00F0, 1'b0};
    vt[6]  = '{1'b0, 32'd0, 32'h0000_1234, 4'b0110,
               32'h1234_0000, 1'b0};
    vt[7]  = '{1'b1, 32'd4, 32'h8000_0000, 4'b1111,
               32'hF800_0000, 1'b0};
    vt[8]  = '{1'b0, 32'd4, 32'd1, 4'b0011, 32'd16, 1'b0};
    vt[9]  = '{1'b1, 32'd4, 32'h8000_0000, 4'b0111,
               32'h0800_0000, 1'b0};
    vt[10] = '{1'b0, 32'd9, 32'd9, 4'b1011, 32'd0, 1'b1};

    ops = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
            4'b0110, 4'b0011, 4'b0111, 4'b1111, 4'b1011,
            4'b1000};

    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 32'd5, 32'd3, 4'b0000);
    set_req(1'b1, 32'd7, 32'd7, 4'b0100);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset rsp_s", bus.rsp_s, 32'd0);
    chk("reset rsp_z", 32'(bus.rsp_z), 32'd1);
    step();
    reset = 1'b0;

    // both requesters busy: grants must alternate 0,1,0,1
    @(negedge clock);
    chk("first grant", 32'(bus.req_ready), 32'd1);
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (c > 0) @(negedge clock);
      if (bus.rsp_valid) begin
        chk("alt rsp_s", bus.rsp_s, bus.rsp_id ? 32'd0 : 32'd8);
        chk("alt rsp_z", 32'(bus.rsp_z), bus.rsp_id ? 32'd1 : 32'd0);
      end
      if ((bus.req_valid & bus.req_ready) != 2'b00)
        got.push_back(int'(bus.req_ready[1]));
    end
    step();
    bus.req_valid = 2'b00;
    chk("alt count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++)
      chk("alt order", 32'(got[i]), 32'(i % 2));
    repeat (3) step();

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

    // response backpressure with a queued request
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 32'd5, 32'd3, 4'b0000);
    bus.req_valid = 2'b01;
    wait_acc("bp accept", 1'b0);
    step();
    set_req(1'b1, 32'd9, 32'd4, 4'b0100);
    bus.req_valid = 2'b10;
    wait_rsp(lat);
    chk("bp latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 3; k++) begin
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp rsp_s", bus.rsp_s, 32'd8);
      chk("bp rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp req_ready", 32'(bus.req_ready), 32'd0);
      if (k < 2) @(negedge clock);
    end
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("drain accept", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk("drain latency", 32'(lat), 32'(LAT));
    chk("drain rsp_id", 32'(bus.rsp_id), 32'd1);
    chk("drain rsp_s", bus.rsp_s, 32'd5);
    step();

    // reset while a response is pending
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 32'd1, 32'd2, 4'b0000);
    bus.req_valid = 2'b10;
    wait_acc("mid accept", 1'b1);
    step();
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk("mid rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid flush rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid flush rsp_id", 32'(bus.rsp_id), 32'd0);
    step();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("no replay", 32'(bus.rsp_valid), 32'd0);
    end
    step();
    bus.req_valid = 2'b11;
    @(negedge clock);
    chk("last after reset", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b00;
    repeat (4) step();

    // randomized traffic against the scoreboard
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_m   = 1'b1;
    acc_bits = 2'b00;
    mon_en   = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] || acc_bits[i]) begin
          logic [31:0] a;
          logic [31:0] b;
          a = ($urandom % 2 == 0) ? 32'($urandom % 40) : $urandom;
          b = ($urandom % 4 == 0) ? a : $urandom;
          set_req(i[0], a, b, ops[$urandom % 11]);
          bus.req_valid[i] = ($urandom % 3) != 0;
        end
      end
      bus.rsp_ready = ($urandom % 4) != 0;
    end
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    mon_en = 1'b0;
    chk("rnd drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
